// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one fas bit cell walks the operands
// LSB first, with the carry/borrow held in a flip-flop between cycles.

module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  // Subtract uses the borrow form, so cin is the incoming borrow.
  assign cout = a_ns ? ((a & b) | (cin & (a ^ b)))
                     : ((~a & b) | (cin & ~(a ^ b)));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ns,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             op;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_bit;
  logic             last_bit;

  fas u_fas (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .a_ns (op),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Signed overflow from the operand sign bits and the final result sign bit.
  function automatic logic ovf_calc(input logic add, input logic am,
                                    input logic bm, input logic rm);
    if (add) return (am == bm) && (rm != am);
    else     return (am != bm) && (rm != am);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      op       <= 1'b0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
    end else if (state == RUN) begin
      carry  <= c_bit;
      result <= {s_bit, result[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        state    <= DONE;
        busy     <= 1'b0;
        done     <= 1'b1;
        cout     <= c_bit;
        overflow <= ovf_calc(op, a_msb, b_msb, s_bit);
      end
    end else begin
      // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
      done <= 1'b0;
      if (start) begin
        state  <= RUN;
        busy   <= 1'b1;
        a_sr   <= a;
        b_sr   <= b;
        op     <= a_ns;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        carry  <= 1'b0;
        cnt    <= '0;
        result <= '0;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases plus random
// operations compared against an arithmetic reference model.

module tb_serial_add_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         a_ns;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .a_ns     (a_ns),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic add);
    int sa, sb, sr;
    logic [W:0] u;
    logic c, o;
    sa = $signed(ma);
    sb = $signed(mb);
    if (add) begin
      u  = {1'b0, ma} + {1'b0, mb};
      sr = sa + sb;
      c  = u[W];
    end else begin
      u  = {1'b0, ma} - {1'b0, mb};
      sr = sa - sb;
      c  = (ma < mb);
    end
    o = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return {o, c, u[W-1:0]};
  endfunction

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top);
    a = ta; b = tb_v; a_ns = top; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_done_after_start", done, 0);
  endtask

  task automatic wait_done(output int lat, output logic overlap);
    lat = 0;
    overlap = 1'b0;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (busy && done) overlap = 1'b1;
    end
  endtask

  task automatic check_done(input string tag, input int lat, input logic overlap,
                            input logic [W-1:0] er, input logic ec, input logic eo);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_busy_done_overlap"}, overlap, 0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_overflow"}, overflow, eo);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic top, input logic [W-1:0] er, input logic ec,
                          input logic eo);
    int lat;
    logic ov;
    start_op(ta, tb_v, top);
    wait_done(lat, ov);
    check_done(tag, lat, ov, er, ec, eo);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic ov, seen;
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic rop;

    // Reset held with random inputs
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; a_ns = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom); a = W'($urandom); b = W'($urandom); a_ns = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b1, 8'h96, 1'b0, 1'b1);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
    directed("sub_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    directed("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Starts during RUN are ignored
    start_op(8'h5A, 8'h3C, 1'b1);
    lat = 0;
    ov = 1'b0;
    while (!done && lat < 4 * W) begin
      if (lat == 2 || lat == 5) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); a_ns = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy && done) ov = 1'b1;
    end
    start = 1'b0;
    check_done("ignored_start", lat, ov, 8'h96, 1'b0, 1'b1);

    // Start in the DONE cycle: no idle gap
    directed("back_to_back", 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    start_op(8'h5A, 8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #10 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    directed("after_abort", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);

    // Random operations against the model; operands are scrambled after acceptance
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 1'($urandom);
      m = model(ra, rb, rop);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      start_op(ra, rb, rop);
      a = W'($urandom); b = W'($urandom); a_ns = 1'($urandom);
      wait_done(lat, ov);
      check_done("random", lat, ov, m[W-1:0], m[W], m[W+1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
